// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle multiply/divide unit:
// op encodings, FSM state enum and the iteration count.
package mult_div_unit_pkg;

    localparam int ITERATIONS = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// md_sign_fix: combinational conditional two's-complement negate.
// Ports: value (operand), negate (1 = negate), result.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed mult (radix-2 Booth) / div (restoring).
// Ports: clk, reset (sync, active-high), start, op (0 mult, 1 div), a_in,
//   b_in; busy, done, div_zero, hi_out, lo_out.
// Optional macro MULTDIV_UNSIGNED_EN adds input is_unsigned (multu/divu).
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = ITERATIONS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);

    state_t         state;
    logic [CW-1:0]  cnt;
    // acc: Booth accumulator / partial remainder (one guard bit)
    logic [WIDTH:0] acc;
    // m: multiplicand (sign/zero-extended) or divisor magnitude
    logic [WIDTH:0] m;
    // q: multiplier shifting out / dividend shifting into quotient
    logic [WIDTH-1:0] q;
    logic           q_1;
    logic           op_r;
    logic           sgn_r;
    logic           neg_a;
    logic           neg_b;
    logic           dz_r;

    logic           sgn;
    logic           sa;
    logic           sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    logic [WIDTH:0] booth_sum;
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] acc_nx;
    logic [WIDTH-1:0] q_nx;
    logic           q1_nx;

`ifdef MULTDIV_UNSIGNED_EN
    assign sgn = ~is_unsigned;
`else
    assign sgn = 1'b1;
`endif

    assign sa   = sgn & a_in[WIDTH-1];
    assign sb   = sgn & b_in[WIDTH-1];
    assign busy = (state != IDLE);

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .value  (a_in),
        .negate (sa),
        .result (mag_a)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .value  (b_in),
        .negate (sb),
        .result (mag_b)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .value  (q),
        .negate (neg_a ^ neg_b),
        .result (quo)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .value  (acc[WIDTH-1:0]),
        .negate (neg_a),
        .result (rem)
    );

    // One iteration of the selected datapath.
    always_comb begin
        booth_sum = acc;
        acc_nx    = acc;
        q_nx      = q;
        q1_nx     = q_1;
        r_sh      = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff      = r_sh - m;
        if (op_r == OP_DIV) begin
            // Keep the trial subtraction only when it did not borrow.
            if (!diff[WIDTH]) begin
                acc_nx = diff;
                q_nx   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = r_sh;
                q_nx   = {q[WIDTH-2:0], 1'b0};
            end
        end else if (sgn_r) begin
            unique case ({q[0], q_1})
                2'b01:   booth_sum = acc + m;
                2'b10:   booth_sum = acc - m;
                default: booth_sum = acc;
            endcase
            acc_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_nx   = {booth_sum[0], q[WIDTH-1:1]};
            q1_nx  = q[0];
        end else begin
            // Unsigned: plain add-and-shift, carry lands in the guard bit.
            booth_sum = q[0] ? (acc + m) : acc;
            acc_nx    = {1'b0, booth_sum[WIDTH:1]};
            q_nx      = {booth_sum[0], q[WIDTH-1:1]};
            q1_nx     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            m        <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            op_r     <= 1'b0;
            sgn_r    <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            dz_r     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        op_r  <= op;
                        sgn_r <= sgn;
                        neg_a <= sa;
                        neg_b <= sb;
                        cnt   <= '0;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        if (op == OP_DIV) begin
                            q <= mag_a;
                            m <= {1'b0, mag_b};
                        end else begin
                            q <= b_in;
                            m <= {sa, a_in};
                        end
                        if (op == OP_DIV && b_in == '0) begin
                            dz_r  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            dz_r  <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    q   <= q_nx;
                    q_1 <= q1_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done     <= 1'b1;
                    div_zero <= dz_r;
                    state    <= IDLE;
                    if (!dz_r) begin
                        if (op_r == OP_DIV) begin
                            hi_out <= rem;
                            lo_out <= quo;
                        end else begin
                            hi_out <= acc[WIDTH-1:0];
                            lo_out <= q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard testbench for mult_div_unit: directed mult/div vectors,
// div-by-zero, overflow, ignored restart and mid-operation reset.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           at;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
`ifdef MULTDIV_UNSIGNED_EN
        .is_unsigned (1'b0),
`endif
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                e = sb.pop_front();
                check("hi_out", hi_out, e.hi);
                check("lo_out", lo_out, e.lo);
                check("div_zero", div_zero, e.dz);
                check("done_cycle", cyc, e.at);
            end
        end
        if (div_zero && !done) begin
            vectors++;
            miscompares++;
            $display("FAIL div_zero_alone: got div_zero=1 expected done=1");
        end
    end

    task automatic issue(input logic o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] h,
                         input logic [W-1:0] l, input logic dz,
                         input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        e.hi  = h;
        e.lo  = l;
        e.dz  = dz;
        e.at  = cyc + (dz ? 2 : W + 2);
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    task automatic wait_done(input int exp_busy, input string name);
        int bc;
        int n;
        bc = busy ? 1 : 0;
        n  = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no done expected done", name);
        end else if (exp_busy >= 0) begin
            check({name, "_busy_cycles"}, bc, exp_busy);
        end
    endtask

    task automatic run(input logic o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] h,
                       input logic [W-1:0] l, input logic dz,
                       input string name);
        issue(o, a, b, h, l, dz, 1'b1);
        wait_done(dz ? 1 : W + 1, name);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_dz", div_zero, 0);
        start = 1'b1;
        a_in  = 32'd4;
        b_in  = 32'd4;
        @(negedge clk);
        check("start_under_reset", busy, 0);
        start = 1'b0;
        reset = 1'b0;

        run(OP_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, "m7n3");
        run(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0, "mmin");
        run(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1, 0, "mmax");
        run(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 0, "mn1");
        run(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, "dn7");
        run(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 0, "d7n2");
        run(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 0, "d100");
        run(OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 0, "dnn");
        run(OP_DIV, 32'd0, 32'd5, 32'd0, 32'd0, 0, "d0n");
        run(OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 0, "m3x5");
        run(OP_DIV, 32'd5, 32'd0, 32'd0, 32'd15, 1, "dz");
        run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, "dovf");

        issue(OP_MULT, 32'd7, 32'd9, 32'd0, 32'd63, 0, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_DIV;
        a_in  = 32'd100;
        b_in  = 32'd100;
        @(negedge clk);
        start = 1'b0;
        wait_done(-1, "repulse");

        issue(OP_MULT, 32'h1234, 32'h5678, 32'd0, 32'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_hi", hi_out, 0);
        check("abort_lo", lo_out, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle", busy, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
